seg_scan_display: RTL and testbench
===================================

Name: seg_scan_display

Overview:
- Parametrised multiplexed seven-segment display controller, successor to the fixed 4-digit top-level display path.
- Selects one of NUM_SRC data words (e.g. register value, instruction, PC) and shows one NUM_DIGITS-nibble page of it.
- Pages advance on a debounced button pulse. Includes an internal scan prescaler, tear-free frame snapshot and optional leading-zero blanking.
- Sits between the processor debug outputs and the board's segment/anode pins.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits (>=2).
- DATA_W, 32, width of each source word; must be a multiple of 4*NUM_DIGITS.
- NUM_SRC, 2, number of selectable source words (>=2).
- SCAN_DIV, 50000, clk cycles per digit slot (>=2).
- NUM_PAGES, DATA_W/(4*NUM_DIGITS), derived; not overridden.

Ports:
- clk  input  1  system clock; all state on rising edge.
- reset  input  1  synchronous, active-low reset.
- src_data  input  NUM_SRC*DATA_W  packed sources; source k = bits [k*DATA_W +: DATA_W].
- src_sel  input  $clog2(NUM_SRC)  source select; values >= NUM_SRC display all zeros.
- page_next  input  1  single-cycle pulse (already debounced); advance page.
- blank_lz  input  1  1 = blank leading-zero digits.
- seg  output  7  seg[0]=a..seg[6]=g, active-low.
- dp  output  1  decimal point, active-low.
- adrive  output  NUM_DIGITS  digit enables, active-low; adrive[d] = digit d, d=0 rightmost/least significant.
- page  output  $clog2(NUM_PAGES) (min 1)  current live page index.

Behaviour:
- Reset (reset=0 at a clk edge) clears:
  - prescaler, digit index d, page, frame snapshot and frame page to 0.
  - adrive to all-ones, seg to 7'b1111111, dp to 1.
  - Reset mid-frame aborts immediately; no partial digit persists.
- Prescaler:
  - Counts 0..SCAN_DIV-1 and wraps.
  - tick is asserted in the cycle count==SCAN_DIV-1.
- Digit index d advances on tick: 0,1,..,NUM_DIGITS-1,0.
- Frame snapshot:
  - On a tick where d wraps to 0 (and on the first tick after reset), latch the selected source word into snap and the live page into frame_page.
  - All digits of a frame use snap and frame_page, so src_data, src_sel or page changes never tear a frame.
  - Such changes appear from the next frame start.
- Nibble for digit d: snap[frame_page*4*NUM_DIGITS + 4*d +: 4].
- Outputs are registered and update the cycle after tick (latency 1).
- Between tick updates, outputs hold. Exactly one adrive bit is low after the first tick.
- Hex encoding (active-low abcdefg):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000.
- Leading-zero blanking:
  - When blank_lz=1, digit d shows blank (1111111) if it and all higher digits of the frame page are zero.
  - Digit 0 is never blanked, so an all-zero page shows a single "0".
  - adrive still scans the blanked digit.
- dp is low only while digit d == frame_page (if frame_page < NUM_DIGITS) is driven. This marks the page index.
- Page register:
  - page_next=1 sets page <= (page==NUM_PAGES-1) ? 0 : page+1.
  - Pulses held high advance every cycle; debouncing is the caller's job.
  - page_next coincident with a frame-start tick: the snapshot takes the old page; the new page is shown from the following frame.
  - page_next during reset is ignored.
- src_sel out of range: the snapshot is all zeros.

Test Plan:
- Defaults with SCAN_DIV=4; hold reset=0 for 3 cycles -> adrive=4'b1111, seg=7'b1111111, dp=1, page=0 throughout. First tick 4 cycles after release; next cycle adrive=4'b1110.
- src0=32'h1234ABCD, src_sel=0, blank_lz=0, run 2 frames:
  - adrive sequence 1110,1101,1011,0111, each held 4 cycles.
  - seg = D(1000010), C(0110001), B(1100000), A(0001000).
  - dp low only on digit 0.
- Same data, one page_next pulse -> page=1; next frame shows 4,3,2,1 (1001100,0000110,0010010,1001111) with dp low on digit 1. A second pulse wraps page to 0.
- src1=32'h0000_00F0, src_sel switched to 1 mid-frame -> current frame completes with the old source. Next frame with blank_lz=1: digits 3,2 blank; digit1=F, digit0=0. With src1=0, only digit 0 shows "0".
- page_next asserted in the same cycle as a frame-start tick -> that frame shows the old page; page output updates next cycle; the following frame shows the new page.
- reset asserted in the middle of digit 2 -> next cycle all outputs return to reset values. After release, the scan restarts at digit 0 with page 0.

Source files
------------

// File: rtl/seg_scan_display.sv
// seg_scan_display: multiplexed seven-segment display controller.
// Selects one of NUM_SRC source words and shows one NUM_DIGITS-nibble page of
// it. Digits are scanned at clk/SCAN_DIV per digit slot. The source word and
// page are captured at each frame start, so no frame ever mixes two values.
// Segment, decimal-point and anode outputs are active-low, with seg[0]=a and
// seg[6]=g.
module seg_scan_display #(
   parameter  int NUM_DIGITS = 4,
   parameter  int DATA_W     = 32,
   parameter  int NUM_SRC    = 2,
   parameter  int SCAN_DIV   = 50000,
   localparam int NUM_PAGES  = DATA_W / (4 * NUM_DIGITS),
   localparam int SEL_W      = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1,
   localparam int PAGE_W     = (NUM_PAGES > 1) ? $clog2(NUM_PAGES) : 1
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [NUM_SRC*DATA_W-1:0]   src_data,
   input  logic [SEL_W-1:0]            src_sel,
   input  logic                        page_next,
   input  logic                        blank_lz,
   output logic [6:0]                  seg,
   output logic                        dp,
   output logic [NUM_DIGITS-1:0]       adrive,
   output logic [PAGE_W-1:0]           page
);

   localparam int CNT_W     = $clog2(SCAN_DIV);
   localparam int DIG_W     = $clog2(NUM_DIGITS);
   localparam int PAGE_BITS = 4 * NUM_DIGITS;

   // The scanner idles until the first tick after reset, which starts frame 0
   // on digit 0. From then on every tick advances to the next digit.
   typedef enum logic [0:0] {
      ST_WAIT = 1'b0,
      ST_SCAN = 1'b1
   } scan_state_t;

   scan_state_t             r_state;
   scan_state_t             w_state_next;

   logic [CNT_W-1:0]        r_cnt;
   logic [DIG_W-1:0]        r_dig;
   logic [DATA_W-1:0]       r_snap;
   logic [PAGE_W-1:0]       r_frame_page;
   logic [PAGE_W-1:0]       r_page;
   logic [6:0]              r_seg;
   logic                    r_dp;
   logic [NUM_DIGITS-1:0]   r_adrive;

   logic                    w_tick;
   logic [DIG_W-1:0]        w_dig_next;
   logic                    w_frame_start;
   logic [DATA_W-1:0]       w_sel_word;
   logic [DATA_W-1:0]       w_snap_use;
   logic [PAGE_W-1:0]       w_fpage_use;
   logic [PAGE_BITS-1:0]    w_page_word;
   logic [3:0]              w_nibble;
   logic [NUM_DIGITS-1:0]   w_digit_nz;
   logic [NUM_DIGITS-1:0]   w_digit_lit;
   logic                    w_blank;
   logic [6:0]              w_seg_next;
   logic                    w_dp_next;
   logic [NUM_DIGITS-1:0]   w_adrive_next;
   logic [PAGE_W-1:0]       w_page_inc;

   // Hex digit to active-low segment pattern, bit 0 = segment a.
   function automatic logic [6:0] hex_to_seg(input logic [3:0] i_nib);
      logic [6:0] v_seg;
      case (i_nib)
         4'h0:    v_seg = 7'b1000000;
         4'h1:    v_seg = 7'b1111001;
         4'h2:    v_seg = 7'b0100100;
         4'h3:    v_seg = 7'b0110000;
         4'h4:    v_seg = 7'b0011001;
         4'h5:    v_seg = 7'b0010010;
         4'h6:    v_seg = 7'b0000010;
         4'h7:    v_seg = 7'b1111000;
         4'h8:    v_seg = 7'b0000000;
         4'h9:    v_seg = 7'b0010000;
         4'hA:    v_seg = 7'b0001000;
         4'hB:    v_seg = 7'b0000011;
         4'hC:    v_seg = 7'b1000110;
         4'hD:    v_seg = 7'b0100001;
         4'hE:    v_seg = 7'b0000110;
         4'hF:    v_seg = 7'b0001110;
         default: v_seg = 7'b1111111;
      endcase
      return v_seg;
   endfunction

   // Scan tick: last cycle of each digit slot.
   assign w_tick = (r_cnt == CNT_W'(SCAN_DIV - 1));

   // Prescaler counts 0..SCAN_DIV-1 and wraps.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_cnt <= '0;
      end else if (w_tick) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   // Scanner state register.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state <= ST_WAIT;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next state and next digit index; the first tick after reset shows digit 0.
   always_comb begin
      w_state_next = r_state;
      w_dig_next   = r_dig;
      case (r_state)
         ST_WAIT: begin
            w_dig_next = '0;
            if (w_tick) begin
               w_state_next = ST_SCAN;
            end else begin
               w_state_next = ST_WAIT;
            end
         end
         ST_SCAN: begin
            w_state_next = ST_SCAN;
            if (r_dig == DIG_W'(NUM_DIGITS - 1)) begin
               w_dig_next = '0;
            end else begin
               w_dig_next = r_dig + DIG_W'(1);
            end
         end
         default: begin
            w_state_next = ST_WAIT;
            w_dig_next   = '0;
         end
      endcase
   end

   assign w_frame_start = w_tick && (w_dig_next == '0);

   // Source mux; select values with no matching source give an all-zero word.
   always_comb begin
      w_sel_word = '0;
      for (int k = 0; k < NUM_SRC; k++) begin
         w_sel_word = w_sel_word |
            (src_data[k*DATA_W +: DATA_W] & {DATA_W{src_sel == SEL_W'(k)}});
      end
   end

   // At a frame start the digit being loaded must already see the new
   // snapshot and page, so bypass the registers in that cycle.
   assign w_snap_use  = w_frame_start ? w_sel_word : r_snap;
   assign w_fpage_use = w_frame_start ? r_page     : r_frame_page;
   assign w_page_word = PAGE_BITS'(w_snap_use >> (int'(w_fpage_use) * PAGE_BITS));
   assign w_nibble    = 4'(w_page_word >> (int'(w_dig_next) * 4));

   // Per-digit "this or any higher digit is non-zero" flags for blanking.
   always_comb begin
      logic v_run;
      v_run       = 1'b0;
      w_digit_nz  = '0;
      w_digit_lit = '0;
      for (int d = NUM_DIGITS - 1; d >= 0; d--) begin
         w_digit_nz[d]  = |w_page_word[4*d +: 4];
         v_run          = v_run | w_digit_nz[d];
         w_digit_lit[d] = v_run;
      end
   end

   // Blank decision, segment pattern, decimal point and anode for the next slot.
   always_comb begin
      w_blank = 1'b0;
      if (blank_lz && (w_dig_next != '0)) begin
         w_blank = !w_digit_lit[w_dig_next];
      end else begin
         w_blank = 1'b0;
      end
      if (w_blank) begin
         w_seg_next = 7'b1111111;
      end else begin
         w_seg_next = hex_to_seg(w_nibble);
      end
      if ((int'(w_fpage_use) < NUM_DIGITS) && (int'(w_fpage_use) == int'(w_dig_next))) begin
         w_dp_next = 1'b0;
      end else begin
         w_dp_next = 1'b1;
      end
      w_adrive_next = ~(NUM_DIGITS'(1) << w_dig_next);
   end

   // Digit index and frame snapshot; the snapshot changes only at frame start.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_dig        <= '0;
         r_snap       <= '0;
         r_frame_page <= '0;
      end else if (w_tick) begin
         r_dig        <= w_dig_next;
         r_snap       <= w_snap_use;
         r_frame_page <= w_fpage_use;
      end else begin
         r_dig        <= r_dig;
         r_snap       <= r_snap;
         r_frame_page <= r_frame_page;
      end
   end

   // Live page wraps after the last page.
   assign w_page_inc = (r_page == PAGE_W'(NUM_PAGES - 1)) ? '0 : (r_page + PAGE_W'(1));

   // Live page register; every cycle with page_next high advances one page.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_page <= '0;
      end else if (page_next) begin
         r_page <= w_page_inc;
      end else begin
         r_page <= r_page;
      end
   end

   // Registered display outputs load one cycle after each tick and hold between.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_seg    <= 7'b1111111;
         r_dp     <= 1'b1;
         r_adrive <= '1;
      end else if (w_tick) begin
         r_seg    <= w_seg_next;
         r_dp     <= w_dp_next;
         r_adrive <= w_adrive_next;
      end else begin
         r_seg    <= r_seg;
         r_dp     <= r_dp;
         r_adrive <= r_adrive;
      end
   end

   assign seg    = r_seg;
   assign dp     = r_dp;
   assign adrive = r_adrive;
   assign page   = r_page;

endmodule

// File: tb/tb_seg_scan_display.sv
// Scoreboard bench for seg_scan_display. A reference model pushes the expected
// display state at each scan tick; a monitor pops an entry every time the DUT
// lights a new digit and also checks page and reset outputs every cycle.
module tb_seg_scan_display;

   localparam int ND    = 4;
   localparam int DW    = 32;
   localparam int NS    = 3;
   localparam int SD    = 4;
   localparam int NP    = DW / (4 * ND);
   localparam int FRAME = SD * ND;

   logic              clk;
   logic              reset;
   logic [NS*DW-1:0]  src_data;
   logic [1:0]        src_sel;
   logic              page_next;
   logic              blank_lz;
   logic [6:0]        seg;
   logic              dp;
   logic [ND-1:0]     adrive;
   logic [0:0]        page;

   seg_scan_display #(
      .NUM_DIGITS (ND),
      .DATA_W     (DW),
      .NUM_SRC    (NS),
      .SCAN_DIV   (SD)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .src_data  (src_data),
      .src_sel   (src_sel),
      .page_next (page_next),
      .blank_lz  (blank_lz),
      .seg       (seg),
      .dp        (dp),
      .adrive    (adrive),
      .page      (page)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct packed {
      logic [ND-1:0] an;
      logic [6:0]    sg;
      logic          dp;
   } exp_t;

   exp_t q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   n_pop = 0;

   // Segment strings exactly as written "abcdefg" (leftmost char = segment a).
   logic [6:0] hex_str [16] = '{
      7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
      7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
      7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
      7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000 };

   function automatic logic [6:0] exp_seg(input int nib);
      logic [6:0] s;
      logic [6:0] r;
      s = hex_str[nib];
      for (int i = 0; i < 7; i++) r[i] = s[6-i];
      return r;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model state: edges since reset release, live page, frame capture.
   int          m_k    = 0;
   int          m_page = 0;
   bit          m_rst  = 1'b0;
   logic [31:0] m_snap = '0;
   int          m_fpage = 0;

   // Reference model: tick t shows digit t % ND; digit 0 starts a new frame.
   initial begin
      forever begin
         @(posedge clk);
         if (!reset) begin
            m_k    = 0;
            m_page = 0;
            m_rst  = 1'b1;
         end else begin
            m_rst = 1'b0;
            if (m_k % SD == SD - 1) begin
               int   dig;
               int   pw;
               int   nib;
               bit   blank;
               exp_t e;
               dig = (m_k / SD) % ND;
               if (dig == 0) begin
                  m_snap  = (src_sel < NS) ? src_data[src_sel*DW +: DW] : 32'h0;
                  m_fpage = m_page;
               end
               pw    = (m_snap >> (m_fpage * 16)) & 32'hFFFF;
               nib   = (pw >> (4 * dig)) & 15;
               blank = blank_lz && (dig != 0) && ((pw >> (4 * dig)) == 0);
               e.an  = ~(4'b0001 << dig);
               e.sg  = blank ? 7'b1111111 : exp_seg(nib);
               e.dp  = (dig == m_fpage) ? 1'b0 : 1'b1;
               q.push_back(e);
            end
            if (page_next) m_page = (m_page + 1) % NP;
            m_k++;
         end
      end
   end

   // Monitor: pops an expectation whenever a new digit is driven.
   initial begin
      logic [ND-1:0] prev_an;
      exp_t          e;
      prev_an = '1;
      forever begin
         @(negedge clk);
         if (m_rst) begin
            chk("rst_adrive", adrive, 4'hF);
            chk("rst_seg", seg, 7'h7F);
            chk("rst_dp", dp, 1);
         end
         chk("page", page, m_page);
         if ((adrive !== prev_an) && (adrive !== 4'hF)) begin
            if (q.size() == 0) begin
               chk("unexpected_update", adrive, prev_an);
            end else begin
               e = q.pop_front();
               n_pop++;
               chk("adrive", adrive, e.an);
               chk("seg", seg, e.sg);
               chk("dp", dp, e.dp);
            end
         end
         prev_an = adrive;
      end
   end

   // Wait (bounded) until the next posedge is at frame phase ph.
   task automatic wait_phase(input int ph);
      int n;
      n = 0;
      while ((m_k % FRAME != ph) && (n < 3 * FRAME)) begin
         @(negedge clk);
         n++;
      end
      if (n >= 3 * FRAME) chk("wait_phase_timeout", n, 0);
   endtask

   task automatic pulse_page();
      page_next = 1'b1;
      @(negedge clk);
      page_next = 1'b0;
   endtask

   // Stimulus: directed scenarios, then randomized traffic.
   initial begin
      reset     = 1'b0;
      src_data  = '0;
      src_sel   = 2'd0;
      page_next = 1'b0;
      blank_lz  = 1'b0;
      repeat (3) @(negedge clk);

      src_data[31:0] = 32'h1234ABCD;
      reset = 1'b1;
      repeat (2 * FRAME) @(negedge clk);

      pulse_page();
      repeat (2 * FRAME) @(negedge clk);
      pulse_page();
      repeat (2 * FRAME) @(negedge clk);

      src_data[63:32] = 32'h0000_00F0;
      wait_phase(FRAME / 2);
      src_sel  = 2'd1;
      blank_lz = 1'b1;
      repeat (2 * FRAME) @(negedge clk);
      src_data[63:32] = 32'h0;
      repeat (2 * FRAME) @(negedge clk);

      src_sel  = 2'd0;
      blank_lz = 1'b0;
      wait_phase(FRAME - 1);
      pulse_page();
      repeat (2 * FRAME) @(negedge clk);

      wait_phase(2 * SD + 1);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      repeat (2 * FRAME) @(negedge clk);

      src_sel = 2'd3;
      repeat (2 * FRAME) @(negedge clk);

      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 7) == 0) begin
            int s;
            s = $urandom_range(0, NS - 1);
            src_data[s*DW +: DW] = $urandom >> $urandom_range(0, 31);
         end
         if ($urandom_range(0, 15) == 0) src_sel = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 19) == 0) blank_lz = ~blank_lz;
         page_next = ($urandom_range(0, 9) == 0);
         reset     = ($urandom_range(0, 299) != 0);
         @(negedge clk);
      end
      page_next = 1'b0;
      reset     = 1'b1;
      repeat (SD + 2) @(negedge clk);

      chk("queue_drained", q.size(), 0);
      chk("enough_updates", (n_pop >= 300) ? 1 : 0, 1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
